// File: rtl/prom_fetch_bridge_if.sv
// Bus bundle between the instruction-fetch stage, prom_fetch_bridge and
// the Gowin pROM macro. The slave modport is the bridge's view; the master
// modport is the view of the environment (fetch stage plus ROM).
interface prom_fetch_bridge_if #(
    parameter int ROM_AW = 10
);
    // fetch request channel
    logic              req_valid;
    logic              req_ready;
    logic [31:0]       req_addr;
    // fetch response channel
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_data;
    logic              rsp_err;
    // pROM pins
    logic [ROM_AW-1:0] rom_ad;
    logic              rom_ce;
    logic              rom_oce;
    logic              rom_reset;
    logic [31:0]       rom_dout;

    modport slave (
        input  req_valid, req_addr, rsp_ready, rom_dout,
        output req_ready, rsp_valid, rsp_data, rsp_err,
        output rom_ad, rom_ce, rom_oce, rom_reset
    );

    modport master (
        output req_valid, req_addr, rsp_ready, rom_dout,
        input  req_ready, rsp_valid, rsp_data, rsp_err,
        input  rom_ad, rom_ce, rom_oce, rom_reset
    );
endinterface

// File: rtl/prom_fetch_bridge.sv
// prom_fetch_bridge: fetch-bus initiator for a 2^ROM_AW x 32 pROM in
// pipelined read mode (address register + output register).
// Every accepted request carries a (valid, err) tag through a two-stage
// shift register that tracks the ROM's address and output stages; the tag
// leaving stage 2 pushes rom_dout (or zero for an error) into the response
// FIFO. Requests are only accepted while tags in flight plus FIFO entries
// are below RSP_DEPTH, so a FIFO slot always exists when ROM data arrives.
// Optional feature: define PROM_FETCH_ERR_EN to flag misaligned or
// out-of-range addresses with rsp_err instead of aliasing them.
module prom_fetch_bridge #(
    parameter int ROM_AW    = 10,
    parameter int RSP_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    prom_fetch_bridge_if.slave   bus
);
    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = CW + 1;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } rsp_t;

    typedef enum logic {
        ST_ROM_RST,
        ST_RUN
    } state_e;

    state_e         state_q, state_d;
    logic           rom_rst;
    logic           bad;
    logic           accept;
    logic           push;
    logic           pop;
    logic           rsp_vld;
    logic [OW-1:0]  occ;
    logic [1:0]     vld_pipe_q, vld_pipe_d;
    logic [1:0]     err_pipe_q, err_pipe_d;
    logic [PW-1:0]  wptr_q, wptr_d;
    logic [PW-1:0]  rptr_q, rptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    rsp_t           mem_q [RSP_DEPTH];
    rsp_t           push_ent;
    rsp_t           head;

    // ROM reset sequencer state: reset forces ST_ROM_RST asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_ROM_RST;
        else        state_q <= state_d;
    end

    // hold rom_reset for exactly the first edge after reset release
    always_comb begin
        state_d = state_q;
        rom_rst = 1'b0;
        case (state_q)
            ST_ROM_RST: begin
                rom_rst = 1'b1;
                state_d = ST_RUN;
            end
            ST_RUN: state_d = ST_RUN;
        endcase
    end

`ifdef PROM_FETCH_ERR_EN
    assign bad = (bus.req_addr[1:0] != 2'b00) | (bus.req_addr[31:ROM_AW+2] != '0);
`else
    // without error checking the low bits are ignored and upper bits alias
    logic unused_addr;
    assign bad         = 1'b0;
    assign unused_addr = ^{bus.req_addr[31:ROM_AW+2], bus.req_addr[1:0]};
`endif

    // credit: reads in flight plus queued responses must stay below depth
    assign occ    = OW'(vld_pipe_q[0]) + OW'(vld_pipe_q[1]) + OW'(cnt_q);
    assign bus.req_ready = ~rom_rst & (occ < OW'(RSP_DEPTH));
    assign accept = bus.req_valid & bus.req_ready;

    assign bus.rom_ad    = bus.req_addr[ROM_AW+1:2];
    assign bus.rom_ce    = accept & ~bad;
    assign bus.rom_oce   = ~rom_rst;
    assign bus.rom_reset = rom_rst;

    // tag shift: bit 0 mirrors the ROM address stage, bit 1 its output stage
    always_comb begin
        vld_pipe_d = {vld_pipe_q[0], accept};
        err_pipe_d = {err_pipe_q[0], accept & bad};
    end

    // tag pipeline registers; reset discards reads in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
            err_pipe_q <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            err_pipe_q <= err_pipe_d;
        end
    end

    assign rsp_vld       = (cnt_q != '0);
    assign push          = vld_pipe_q[1];
    assign pop           = rsp_vld & bus.rsp_ready;
    assign push_ent.err  = err_pipe_q[1];
    assign push_ent.data = err_pipe_q[1] ? 32'h0 : bus.rom_dout;

    // FIFO pointer/count next state; simultaneous push and pop keep count
    always_comb begin
        wptr_d = wptr_q + PW'(push);
        rptr_d = rptr_q + PW'(pop);
        cnt_d  = cnt_q + CW'(push) - CW'(pop);
    end

    // FIFO pointers and count; reset empties the queue immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // FIFO storage; contents are don't-care until written, outputs are gated
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= push_ent;
    end

    assign head          = mem_q[rptr_q];
    assign bus.rsp_valid = rsp_vld;
    assign bus.rsp_data  = rsp_vld ? head.data : 32'h0;

`ifdef PROM_FETCH_ERR_EN
    assign bus.rsp_err = rsp_vld & head.err;
`else
    logic unused_err;
    assign bus.rsp_err = 1'b0;
    assign unused_err  = head.err;
`endif

endmodule

// File: doc/prom_fetch_bridge.md
# prom_fetch_bridge

Initiator-side bridge between the CPU instruction-fetch valid/ready bus and the 1K×32 Gowin pROM macro (pipelined read mode: address register plus output register). It accepts byte-addressed fetch requests, drives the ROM address, chip-enable, output-enable and reset pins, and tracks reads in flight through the ROM's two-stage pipeline. It returns read data in request order through a 4-entry response FIFO, so the fetch stage can apply backpressure without losing ROM data.

## Interface
- `ROM_AW`, default 10: ROM word-address width; the ROM holds 2^ROM_AW words.
- `RSP_DEPTH`, default 4: response FIFO depth (power of two, ≥ 3).
- `clk` in 1: single clock for the bridge and the ROM.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: fetch request valid.
- `req_ready` out 1: bridge can accept a request.
- `req_addr` in 32: byte address.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_data` out 32: fetched word.
- `rsp_err` out 1: the request was misaligned or out of range.
- `rom_ad` out ROM_AW: ROM word address, equal to `req_addr[ROM_AW+1:2]`.
- `rom_ce` out 1: ROM address-stage enable.
- `rom_oce` out 1: ROM output-register enable.
- `rom_reset` out 1: ROM synchronous reset, active-high.
- `rom_dout` in 32: ROM output-register data.

## Operation
- **Accept.** A request is accepted on a clock edge when `req_valid & req_ready` are both high.
- **ROM issue.** `rom_ce = req_valid & req_ready & ~bad`, where `bad` is the error condition below. Bad requests never read the ROM.
- **Tag pipeline.** Each accepted request pushes a tag (valid, err) into a two-stage shift register, s1 then s2, which mirrors the ROM's address and output stages.
- **FIFO push.** When the s2 tag is valid it is pushed into the response FIFO. The pushed data is `rom_dout`, or 32'h0 if the tag's err bit is set.
- **Credit rule.** `req_ready = (s1.v + s2.v + fifo_count) < RSP_DEPTH`. This guarantees that every read in flight has a FIFO slot, so no ROM stall path exists.
- **Output enable.** `rom_oce` is held at 1 whenever `rom_reset` is 0.
- **Ordering.** Responses are returned strictly in acceptance order; error and good requests interleave in that order.
- **FIFO.** Circular buffer with wrap-around pointers and a count. Push and pop in the same cycle leave the count unchanged, and this is legal even when the FIFO is full or empty.
- **Outputs.** `rsp_valid = (fifo_count != 0)`. `rsp_data` and `rsp_err` come from the FIFO head.
- **ROM reset sequencing.** `rom_reset` is set to 1 asynchronously by reset. It is cleared on the first clock edge after `rst_n` rises. `req_ready` stays 0 while `rom_reset` is 1.
- **Reset mid-operation.** Asserting `rst_n` low clears the tags, the FIFO pointers and the count immediately. Any reads in flight are discarded.

## Timing
- **Reset values:** `req_ready`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, `rom_ce`=0, `rom_oce`=0, `rom_reset`=1. `rom_ad` follows `req_addr` combinationally.
- **Latency:** a request accepted at edge N is pushed at edge N+2. `rsp_valid` is high in the cycle after edge N+2, i.e. 2 cycles from acceptance to response.
- **Throughput:** with `rsp_ready` held at 1, one request is accepted per cycle indefinitely, because steady-state occupancy is 3 and the limit is 4.
- **Backpressure:** with `rsp_ready` at 0, at most RSP_DEPTH requests are accepted, then `req_ready` drops. `req_ready` recovers the cycle after the first pop.
- **ROM pin timing:** `rom_ce` and `rom_ad` are valid in the same cycle as the accept. The ROM samples them at edge N.

## Configuration
- The macro `PROM_FETCH_ERR_EN` selects error checking.
- **Defined:**
  - `bad = (req_addr[1:0] != 0) | (req_addr[31:ROM_AW+2] != 0)`.
  - A bad request returns `rsp_err`=1 and `rsp_data`=0, and no ROM access occurs.
- **Undefined:**
  - `bad` is tied to 0 and `rsp_err` is tied to 0.
  - Low address bits are ignored.
  - Upper address bits alias, i.e. only `req_addr[ROM_AW+1:2]` are used.

## Test plan
Use a bench ROM model in pipelined read mode with word[i] = 32'hA500_0000 | i.
- **Single fetch:** reset, then fetch addr 0x0000_0010 with `rsp_ready`=1 → `rom_ad`=4; `rsp_valid` 2 cycles after acceptance with data 32'hA500_0004 and err=0.
- **Streaming:** back-to-back fetches at 0x0, 0x4, …, 0xFC with `rsp_ready`=1 → `req_ready` never drops after reset release; 64 in-order responses at 1 per cycle.
- **Backpressure:** hold `rsp_ready`=0 and drive `req_valid`=1 → exactly 4 requests accepted, then `req_ready`=0. Raise `rsp_ready` → 4 responses in order, and `req_ready` returns 1 the cycle after the first pop.
- **Error interleave (with `PROM_FETCH_ERR_EN`):** fetch 0x8, 0x2, 0x1000, 0xC → responses A500_0002/err0, 0/err1, 0/err1, A500_0003/err0. `rom_ce`=0 on both bad accepts.
- **Aliasing (without the macro):** fetch 0x1008 → data 32'hA500_0002, err=0.
- **Reset mid-stream:** pulse `rst_n` low with 2 reads in flight and 2 in the FIFO → `rsp_valid`=0 and `rom_reset`=1 immediately; after release, the first new fetch of 0x0 returns A500_0000 with no stale responses.
